// File: rtl/password_enroll.sv
// password_enroll
//
// Enrollment front end for the switch-operated lock. The user types a new
// 4-digit code, types it again to confirm, and the code is stored only when
// both entries match exactly. The stored code is published to the lock checker.
//
// Parameters:
//   HOLD_CYCLES  - number of cycles the SAVED / ERR result screens stay up (>= 1)
//   DEFAULT_CODE - code loaded at reset, digit 0 in the most significant nibble
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   enroll_start - one-cycle pulse requesting (or restarting) enrollment
//   key_pulse    - debounced one-shot key pulses, bit n = digit n
//   code0..code3 - stored code digits, code0 entered first
//   code_update  - one-cycle pulse in the first cycle a new code is visible
//   busy         - high whenever the block is not idle
//   HEX0..HEX4   - active-low 7-segment patterns (gfedcba)
module password_enroll #(
    parameter int unsigned HOLD_CYCLES  = 5,
    parameter logic [15:0] DEFAULT_CODE = {4'd8, 4'd5, 4'd2, 4'd1}
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enroll_start,
    input  logic [9:0] key_pulse,
    output logic [3:0] code0,
    output logic [3:0] code1,
    output logic [3:0] code2,
    output logic [3:0] code3,
    output logic       code_update,
    output logic       busy,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4
);

    typedef enum logic [2:0] {IDLE, ENTER, CONFIRM, SAVED, ERR} state_t;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_O_UP  = 7'b1000000;
    localparam logic [6:0] SEG_N     = 7'b1001000;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O_LO  = 7'b0100011;

    localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYCLES - 1);

    state_t          state, state_n;
    logic [1:0]      idx, idx_n;
    logic [3:0][3:0] stage, stage_n;
    logic [27:0]     hold, hold_n;
    logic            commit;
    logic            key_valid, key_invalid;
    logic [3:0]      key_digit;
    logic [34:0]     hex_q, hex_n;

    // Classify the key bus: exactly one bit is a digit, more than one is a
    // fumbled press that aborts the enrollment.
    always_comb begin
        key_valid   = $onehot(key_pulse);
        key_invalid = (key_pulse != 10'd0) && !key_valid;
        key_digit   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_pulse[i]) key_digit = 4'(i);
        end
    end

    // Next-state logic. A restart request in ENTER/CONFIRM wins over any key
    // arriving on the same cycle; the result screens ignore all inputs.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        stage_n = stage;
        hold_n  = '0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (enroll_start) begin
                    state_n = ENTER;
                    idx_n   = 2'd0;
                end
            end
            ENTER: begin
                if (enroll_start) begin
                    state_n = ENTER;
                    idx_n   = 2'd0;
                end else if (key_valid) begin
                    stage_n[idx] = key_digit;
                    idx_n        = idx + 2'd1;
                    if (idx == 2'd3) state_n = CONFIRM;
                end else if (key_invalid) begin
                    state_n = ERR;
                    idx_n   = 2'd0;
                end
            end
            CONFIRM: begin
                if (enroll_start) begin
                    state_n = ENTER;
                    idx_n   = 2'd0;
                end else if (key_valid && key_digit == stage[idx]) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_n = SAVED;
                        commit  = 1'b1;
                    end
                end else if (key_valid || key_invalid) begin
                    state_n = ERR;
                    idx_n   = 2'd0;
                end
            end
            SAVED, ERR: begin
                hold_n = hold + 28'd1;
                if (hold == HOLD_LAST) begin
                    state_n = IDLE;
                    idx_n   = 2'd0;
                    hold_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = 2'd0;
            end
        endcase
    end

    // Display decode for the upcoming state, so the registered segments track
    // state and idx with no extra cycle of lag. HEX3 shows digit position 0.
    always_comb begin
        hex_n = {5{SEG_DASH}};
        case (state_n)
            ENTER, CONFIRM: begin
                hex_n[34:28] = (state_n == ENTER) ? SEG_E : SEG_C;
                for (int p = 0; p < 4; p++) begin
                    hex_n[(3 - p) * 7 +: 7] = (2'(p) < idx_n) ? SEG_DASH : SEG_BLANK;
                end
            end
            SAVED:   hex_n = {SEG_BLANK, SEG_D, SEG_O_UP, SEG_N, SEG_E};
            ERR:     hex_n = {SEG_E, SEG_R, SEG_R, SEG_O_LO, SEG_R};
            default: hex_n = {5{SEG_DASH}};
        endcase
    end

    // State and all outputs are registered; the code only changes on commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= 2'd0;
            stage       <= '0;
            hold        <= '0;
            code0       <= DEFAULT_CODE[15:12];
            code1       <= DEFAULT_CODE[11:8];
            code2       <= DEFAULT_CODE[7:4];
            code3       <= DEFAULT_CODE[3:0];
            code_update <= 1'b0;
            busy        <= 1'b0;
            hex_q       <= {5{SEG_DASH}};
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            stage       <= stage_n;
            hold        <= hold_n;
            code_update <= commit;
            busy        <= (state_n != IDLE);
            hex_q       <= hex_n;
            if (commit) begin
                code0 <= stage[0];
                code1 <= stage[1];
                code2 <= stage[2];
                code3 <= stage[3];
            end
        end
    end

    assign HEX4 = hex_q[34:28];
    assign HEX3 = hex_q[27:21];
    assign HEX2 = hex_q[20:14];
    assign HEX1 = hex_q[13:7];
    assign HEX0 = hex_q[6:0];

endmodule

// File: tb/tb_password_enroll.sv
// tb_password_enroll
//
// Bench for password_enroll. Directed scenarios plus a randomized phase, all
// checked every cycle against a behavioural model that tracks the typed digits
// in a queue, a count of confirmed digits and a countdown for result screens.
module tb_password_enroll;

    localparam int HOLD = 5;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] S_E   = 7'b0000110;
    localparam logic [6:0] S_C   = 7'b1000110;
    localparam logic [6:0] S_D   = 7'b0100001;
    localparam logic [6:0] S_O   = 7'b1000000;
    localparam logic [6:0] S_N   = 7'b1001000;
    localparam logic [6:0] S_R   = 7'b0101111;
    localparam logic [6:0] S_LO  = 7'b0100011;

    localparam int M_IDLE    = 0;
    localparam int M_ENTER   = 1;
    localparam int M_CONFIRM = 2;
    localparam int M_SAVED   = 3;
    localparam int M_ERR     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enroll_start;
    logic [9:0] key_pulse;
    logic [3:0] code0, code1, code2, code3;
    logic       code_update;
    logic       busy;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4;

    int checks = 0;
    int errors = 0;

    int         m_mode;
    int         m_first[$];
    int         m_matched;
    int         m_dwell;
    logic [3:0] m_code[4];
    logic       m_update;

    password_enroll #(
        .HOLD_CYCLES (HOLD),
        .DEFAULT_CODE({4'd8, 4'd5, 4'd2, 4'd1})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enroll_start(enroll_start),
        .key_pulse   (key_pulse),
        .code0       (code0),
        .code1       (code1),
        .code2       (code2),
        .code3       (code3),
        .code_update (code_update),
        .busy        (busy),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [34:0] observed,
                               input logic [34:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [34:0] expectedHex();
        logic [34:0] h;
        int n;
        h = {5{DASH}};
        case (m_mode)
            M_ENTER, M_CONFIRM: begin
                n = (m_mode == M_ENTER) ? m_first.size() : m_matched;
                h[34:28] = (m_mode == M_ENTER) ? S_E : S_C;
                for (int p = 0; p < 4; p++) h[(3 - p) * 7 +: 7] = (p < n) ? DASH : BLANK;
            end
            M_SAVED: h = {BLANK, S_D, S_O, S_N, S_E};
            M_ERR:   h = {S_E, S_R, S_R, S_LO, S_R};
            default: h = {5{DASH}};
        endcase
        return h;
    endfunction

    task automatic modelReset();
        m_mode    = M_IDLE;
        m_first.delete();
        m_matched = 0;
        m_dwell   = 0;
        m_code[0] = 4'd8;
        m_code[1] = 4'd5;
        m_code[2] = 4'd2;
        m_code[3] = 4'd1;
        m_update  = 1'b0;
    endtask

    // One clock edge of the reference behaviour, from the enrollment rules.
    task automatic modelStep(input logic s, input logic [9:0] k);
        int ones;
        int d;
        ones = $countones(k);
        d = 0;
        for (int i = 0; i < 10; i++) if (k[i]) d = i;
        m_update = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (s) begin
                    m_mode = M_ENTER;
                    m_first.delete();
                end
            end
            M_ENTER: begin
                if (s) begin
                    m_first.delete();
                end else if (ones == 1) begin
                    m_first.push_back(d);
                    if (m_first.size() == 4) begin
                        m_mode    = M_CONFIRM;
                        m_matched = 0;
                    end
                end else if (ones > 1) begin
                    m_mode  = M_ERR;
                    m_dwell = HOLD;
                end
            end
            M_CONFIRM: begin
                if (s) begin
                    m_mode = M_ENTER;
                    m_first.delete();
                end else if (ones == 1 && d == m_first[m_matched]) begin
                    m_matched++;
                    if (m_matched == 4) begin
                        for (int i = 0; i < 4; i++) m_code[i] = 4'(m_first[i]);
                        m_update = 1'b1;
                        m_mode   = M_SAVED;
                        m_dwell  = HOLD;
                    end
                end else if (ones >= 1) begin
                    m_mode  = M_ERR;
                    m_dwell = HOLD;
                end
            end
            default: begin
                m_dwell--;
                if (m_dwell == 0) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic checkAll();
        checkOutput("busy", 35'(busy), 35'(m_mode != M_IDLE));
        checkOutput("code_update", 35'(code_update), 35'(m_update));
        checkOutput("code", 35'({code0, code1, code2, code3}),
                    35'({m_code[0], m_code[1], m_code[2], m_code[3]}));
        checkOutput("hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, expectedHex());
    endtask

    // Inputs are driven from the falling edge and held across one rising edge.
    task automatic applyStimulus(input logic s, input logic [9:0] k);
        enroll_start = s;
        key_pulse    = k;
        @(posedge clk);
        modelStep(s, k);
        @(negedge clk);
        enroll_start = 1'b0;
        key_pulse    = 10'd0;
        checkAll();
    endtask

    task automatic pressDigit(input int d);
        logic [9:0] k;
        k = 10'd1 << d;
        applyStimulus(1'b0, k);
        applyStimulus(1'b0, 10'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 10'd0);
    endtask

    function automatic logic [9:0] twoKeys();
        int a;
        int b;
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        return (10'd1 << a) | (10'd1 << b);
    endfunction

    initial begin
        rst          = 1'b0;
        enroll_start = 1'b0;
        key_pulse    = 10'd0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll();
        rst = 1'b1;
        @(negedge clk);
        checkAll();
        checkOutput("reset_code", 35'({code0, code1, code2, code3}), 35'(16'h8521));
        checkOutput("reset_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, {5{DASH}});

        // Successful enrollment of 3,7,0,9.
        applyStimulus(1'b1, 10'd0);
        checkOutput("hex4_enter", 35'(HEX4), 35'(S_E));
        pressDigit(3); pressDigit(7); pressDigit(0); pressDigit(9);
        checkOutput("hex4_confirm", 35'(HEX4), 35'(S_C));
        pressDigit(3); pressDigit(7); pressDigit(0);
        applyStimulus(1'b0, 10'd1 << 9);
        checkOutput("commit_pulse", 35'(code_update), 35'(1'b1));
        checkOutput("commit_code", 35'({code0, code1, code2, code3}), 35'(16'h3709));
        idleCycles(HOLD + 2);

        // Confirm mismatch leaves the stored code alone.
        applyStimulus(1'b1, 10'd0);
        pressDigit(1); pressDigit(2); pressDigit(3); pressDigit(4);
        pressDigit(1); pressDigit(2);
        applyStimulus(1'b0, 10'd1 << 5);
        checkOutput("mismatch_err", {HEX4, HEX3, HEX2, HEX1, HEX0}, {S_E, S_R, S_R, S_LO, S_R});
        idleCycles(HOLD + 2);
        checkOutput("mismatch_code", 35'({code0, code1, code2, code3}), 35'(16'h3709));

        // Two keys at once aborts the entry.
        applyStimulus(1'b1, 10'd0);
        pressDigit(4); pressDigit(6);
        applyStimulus(1'b0, 10'b0000100100);
        idleCycles(HOLD + 2);

        // Keys pressed while idle are ignored.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 10'd1 << i);

        // Reset in the middle of an enrollment restores the default code.
        applyStimulus(1'b1, 10'd0);
        pressDigit(6); pressDigit(6);
        #2 rst = 1'b0;
        modelReset();
        #1 checkAll();
        checkOutput("midreset_code", 35'({code0, code1, code2, code3}), 35'(16'h8521));
        @(negedge clk);
        rst = 1'b1;
        idleCycles(2);

        // Restart request wins over a simultaneous matching key.
        applyStimulus(1'b1, 10'd0);
        pressDigit(1); pressDigit(2); pressDigit(3); pressDigit(4);
        pressDigit(1); pressDigit(2);
        applyStimulus(1'b1, 10'd1 << 3);
        checkOutput("restart_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, {S_E, BLANK, BLANK, BLANK, BLANK});
        idleCycles(3);

        // Randomized traffic steered by the model's current phase.
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = $urandom_range(0, 99);
            case (m_mode)
                M_IDLE: begin
                    if (r < 25)      applyStimulus(1'b1, 10'd0);
                    else if (r < 40) applyStimulus(1'b0, 10'd1 << $urandom_range(0, 9));
                    else             applyStimulus(1'b0, 10'd0);
                end
                M_ENTER: begin
                    if (r < 3)       applyStimulus(1'b1, 10'd1 << $urandom_range(0, 9));
                    else if (r < 7)  applyStimulus(1'b0, twoKeys());
                    else if (r < 55) applyStimulus(1'b0, 10'd1 << $urandom_range(0, 9));
                    else             applyStimulus(1'b0, 10'd0);
                end
                M_CONFIRM: begin
                    if (r < 3)       applyStimulus(1'b1, 10'd0);
                    else if (r < 5)  applyStimulus(1'b0, twoKeys());
                    else if (r < 50) applyStimulus(1'b0, 10'd1 << m_first[m_matched]);
                    else if (r < 55) applyStimulus(1'b0, 10'd1 << $urandom_range(0, 9));
                    else             applyStimulus(1'b0, 10'd0);
                end
                default: begin
                    if (r < 30)      applyStimulus(1'b1, 10'd0);
                    else if (r < 60) applyStimulus(1'b0, twoKeys());
                    else             applyStimulus(1'b0, 10'd0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
